// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage Y86-64 pipeline.
// Owns the fetch predicted-PC register and generates the stall/bubble
// controls for the F/D/E/M/W pipeline registers. It detects load/use, ret
// and mispredict hazards and exception draining. A run/drain/halt FSM
// freezes the pipe on halt or error. The block also keeps saturating
// performance counters.
module pipe_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      f_predPC,
  output logic [63:0]      F_predPC,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [1:0]       run_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10,
    ERROR  = 2'b11
  } run_state_e;

  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_HLT = 4'b0100;

  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  run_state_e state, state_next;

  logic active;
  logic m_exc;
  logic w_exc;
  logic w_hlt;
  logic loaduse;
  logic retp;
  logic mispred;

  // Hazard and status terms; hazards only exist while the pipe is running
  always_comb begin
    active  = (state == RUN) || (state == DRAIN);
    m_exc   = (m_stat != STAT_AOK);
    w_exc   = (W_stat != STAT_AOK);
    w_hlt   = (W_stat == STAT_HLT);
    loaduse = active && ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != REG_NONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retp    = active && ((D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET));
    mispred = active && (E_icode == I_JXX) && !e_Cnd;
  end

  // Run-state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: writeback status outranks memory status, any non-halt
  // writeback exception (including malformed codes) is an error
  always_comb begin
    state_next = state;
    case (state)
      RUN, DRAIN: begin
        if (w_hlt) begin
          state_next = HALTED;
        end else if (w_exc) begin
          state_next = ERROR;
        end else if (m_exc && (state == RUN)) begin
          state_next = DRAIN;
        end
      end
      default: state_next = state;
    endcase
  end

  // Pipeline register controls, forced while in reset and frozen once stopped
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    set_cc   = 1'b0;
    if (!rst_n) begin
      F_stall  = 1'b0;
    end else if (!active) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = loaduse | retp;
      D_stall  = loaduse;
      D_bubble = mispred | (retp & !loaduse);
      E_bubble = mispred | loaduse;
      M_bubble = m_exc | w_exc;
      W_stall  = w_exc;
      set_cc   = (E_icode == I_OPQ) & !m_exc & !w_exc;
    end
  end

  assign run_state = state;

  // Fetch predicted-PC register, advances only when fetch is not held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC <= RESET_PC;
    end else if (active && !F_stall) begin
      F_predPC <= f_predPC;
    end
  end

  // Saturating performance counters, frozen outside RUN/DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      loaduse_cnt <= '0;
      mispred_cnt <= '0;
    end else if (active) begin
      if (cycle_cnt != CNT_MAX) begin
        cycle_cnt <= cycle_cnt + CNT_ONE;
      end
      if (loaduse && (loaduse_cnt != CNT_MAX)) begin
        loaduse_cnt <= loaduse_cnt + CNT_ONE;
      end
      if (mispred && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized bench for pipe_ctrl. A second
// instance with 4-bit counters shares all inputs to exercise saturation.
module tb_pipe_ctrl;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_predPC;
  logic [3:0]  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic        e_Cnd;
  logic [3:0]  m_stat, W_stat;

  logic [63:0] F_predPC;
  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
  logic [1:0]  run_state;
  logic [31:0] cycle_cnt, loaduse_cnt, mispred_cnt;

  logic [63:0] s_F_predPC;
  logic        s_F_stall, s_D_stall, s_W_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_set_cc;
  logic [1:0]  s_run_state;
  logic [3:0]  s_cycle_cnt, s_loaduse_cnt, s_mispred_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model state: mode 0 run, 1 drain, 2 halted, 3 error
  int          m_mode;
  logic [63:0] m_pc;
  longint      m_cyc, m_lu, m_mp;
  logic [63:0] saved_pc;
  longint      saved_cyc;

  always #5 clk = ~clk;

  pipe_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .f_predPC(f_predPC), .F_predPC(F_predPC),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .set_cc(set_cc), .run_state(run_state),
    .cycle_cnt(cycle_cnt), .loaduse_cnt(loaduse_cnt), .mispred_cnt(mispred_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .f_predPC(f_predPC), .F_predPC(s_F_predPC),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .W_stall(s_W_stall), .D_bubble(s_D_bubble),
    .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .set_cc(s_set_cc), .run_state(s_run_state),
    .cycle_cnt(s_cycle_cnt), .loaduse_cnt(s_loaduse_cnt), .mispred_cnt(s_mispred_cnt)
  );

  function automatic bit exc(input logic [3:0] s);
    return (s !== 4'b0001);
  endfunction

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) <<< w) - 1;
    return 64'(v > mx ? mx : v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_terms(output bit lu, output bit rp, output bit mp);
    lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mp = (E_icode == 4'd7) && !e_Cnd;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RST_PC;
    m_cyc  = 0;
    m_lu   = 0;
    m_mp   = 0;
  endtask

  // Model's view of one rising edge with the current inputs
  task automatic model_edge();
    bit lu, rp, mp;
    if (rst_n && m_mode < 2) begin
      model_terms(lu, rp, mp);
      if (!(lu || rp)) m_pc = f_predPC;
      m_cyc++;
      if (lu) m_lu++;
      if (mp) m_mp++;
      if (W_stat === 4'b0100)     m_mode = 2;
      else if (exc(W_stat))       m_mode = 3;
      else if (exc(m_stat) && m_mode == 0) m_mode = 1;
    end
  endtask

  task automatic checkOutput();
    bit lu, rp, mp;
    logic fs, ds, ws, db, eb, mb, cc;
    if (!rst_n) begin
      {fs, ds, ws} = 3'b000;
      {db, eb, mb} = 3'b111;
      cc = 1'b0;
    end else if (m_mode >= 2) begin
      {fs, ds, ws} = 3'b111;
      {db, eb, mb} = 3'b111;
      cc = 1'b0;
    end else begin
      model_terms(lu, rp, mp);
      fs = lu | rp;
      ds = lu;
      db = mp | (rp & !lu);
      eb = mp | lu;
      mb = exc(m_stat) | exc(W_stat);
      ws = exc(W_stat);
      cc = (E_icode == 4'd6) && !exc(m_stat) && !exc(W_stat);
    end
    chk("F_stall",     64'(F_stall),   64'(fs));
    chk("D_stall",     64'(D_stall),   64'(ds));
    chk("W_stall",     64'(W_stall),   64'(ws));
    chk("D_bubble",    64'(D_bubble),  64'(db));
    chk("E_bubble",    64'(E_bubble),  64'(eb));
    chk("M_bubble",    64'(M_bubble),  64'(mb));
    chk("set_cc",      64'(set_cc),    64'(cc));
    chk("F_predPC",    F_predPC,       m_pc);
    chk("run_state",   64'(run_state), 64'(m_mode));
    chk("cycle_cnt",   64'(cycle_cnt),   sat(m_cyc, 32));
    chk("loaduse_cnt", 64'(loaduse_cnt), sat(m_lu, 32));
    chk("mispred_cnt", 64'(mispred_cnt), sat(m_mp, 32));
    chk("s_run_state",   64'(s_run_state),   64'(m_mode));
    chk("s_cycle_cnt",   64'(s_cycle_cnt),   sat(m_cyc, 4));
    chk("s_loaduse_cnt", 64'(s_loaduse_cnt), sat(m_lu, 4));
    chk("s_mispred_cnt", 64'(s_mispred_cnt), sat(m_mp, 4));
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [3:0] di, input logic [3:0] ei,
                               input logic [3:0] mi, input logic [3:0] dm, input logic [3:0] sa,
                               input logic [3:0] sb, input logic cnd, input logic [3:0] ms,
                               input logic [3:0] ws);
    f_predPC = pc;
    D_icode  = di;
    E_icode  = ei;
    M_icode  = mi;
    E_dstM   = dm;
    d_srcA   = sa;
    d_srcB   = sb;
    e_Cnd    = cnd;
    m_stat   = ms;
    W_stat   = ws;
  endtask

  // One clock: check before the edge, advance model, check after the edge
  task automatic step();
    #1 checkOutput();
    model_edge();
    @(posedge clk);
    #1 checkOutput();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 model_reset();
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] pick_icode();
    case ($urandom_range(0, 7))
      0: return 4'd5;
      1: return 4'd11;
      2: return 4'd9;
      3: return 4'd7;
      4: return 4'd6;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [3:0] pick_stat(input bit allow, input int odds);
    if (!allow || $urandom_range(0, odds - 1) != 0) return 4'b0001;
    case ($urandom_range(0, 3))
      0: return 4'b0010;
      1: return 4'b0100;
      2: return 4'b1000;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic rand_cycle(input bit allow_exc);
    applyStimulus({$urandom, $urandom}, pick_icode(), pick_icode(), pick_icode(), pick_reg(),
                  pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
                  pick_stat(allow_exc, 15), pick_stat(allow_exc, 30));
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(64'h0, 4'd1, 4'd1, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0001);
    model_reset();
    #12 checkOutput();
    chk("reset_pc", F_predPC, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;

    // Bring the PC to a known value
    applyStimulus(64'h14, 4'd1, 4'd1, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0001);
    step();
    chk("pc_load", F_predPC, 64'h14);

    // Load/use
    applyStimulus(64'h99, 4'd1, 4'd5, 4'd1, 4'd3, 4'd3, 4'd0, 1'b1, 4'b0001, 4'b0001);
    #1 chk("lu_F_stall", 64'(F_stall), 64'd1);
    chk("lu_D_bubble", 64'(D_bubble), 64'd0);
    step();
    chk("lu_pc_hold", F_predPC, 64'h14);
    chk("lu_cnt", 64'(loaduse_cnt), 64'd1);

    // Mispredict
    applyStimulus(64'h40, 4'd1, 4'd7, 4'd1, 4'hF, 4'd0, 4'd0, 1'b0, 4'b0001, 4'b0001);
    step();
    chk("mp_pc", F_predPC, 64'h40);
    chk("mp_cnt", 64'(mispred_cnt), 64'd1);

    // Ret walking down the pipe
    for (int i = 0; i < 3; i++) begin
      applyStimulus({$urandom, $urandom}, 4'd9, 4'd1, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0001);
      step();
    end
    applyStimulus({$urandom, $urandom}, 4'd1, 4'd9, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0001);
    step();
    applyStimulus({$urandom, $urandom}, 4'd1, 4'd1, 4'd9, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0001);
    step();
    chk("ret_pc_hold", F_predPC, 64'h40);

    // Clean random running, enough to saturate the 4-bit counters
    for (int i = 0; i < 20; i++) rand_cycle(1'b0);
    chk("sat_cycle", 64'(s_cycle_cnt), 64'd15);

    // Halt drain
    applyStimulus(64'h77, 4'd1, 4'd1, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0100, 4'b0001);
    step();
    chk("drain_state", 64'(run_state), 64'd1);
    applyStimulus(64'h88, 4'd1, 4'd1, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0100);
    step();
    chk("halt_state", 64'(run_state), 64'd2);
    saved_pc  = F_predPC;
    saved_cyc = longint'(cycle_cnt);
    for (int i = 0; i < 10; i++) rand_cycle(1'b1);
    chk("halt_pc_frozen", F_predPC, saved_pc);
    chk("halt_cyc_frozen", 64'(cycle_cnt), 64'(saved_cyc));

    // Mid-cycle asynchronous reset
    do_reset();
    for (int i = 0; i < 5; i++) rand_cycle(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    checkOutput();
    chk("async_cnt", 64'(cycle_cnt), 64'd0);
    chk("async_pc", F_predPC, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;

    // Address error straight from RUN, with an OPQ in execute
    applyStimulus(64'h50, 4'd1, 4'd6, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b1000);
    #1 chk("err_set_cc", 64'(set_cc), 64'd0);
    step();
    chk("err_state", 64'(run_state), 64'd3);

    // Malformed writeback status behaves as INS
    do_reset();
    applyStimulus(64'h60, 4'd1, 4'd1, 4'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'b0001, 4'b0011);
    step();
    chk("bad_stat_state", 64'(run_state), 64'd3);

    // Long random run, restarting whenever the pipe stops
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_cycle(1'b1);
      if (m_mode >= 2 && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
